// File: rtl/piso_tx_sched.sv
// piso_tx_sched: round-robin scheduler in front of one shared parallel-in/serial-out path.
// Two requesters hand over WIDTH-bit words through valid/ready. The accepted word is sent MSB-first,
// one bit per clk, with first/last/source framing. After each frame there are GAP forced idle cycles.
// Optional feature macro: PISO_PARITY_EN. When it is defined, an even-parity bit is appended to each frame.
//
// Handshake: a word moves on the rising edge where reqN_valid && reqN_ready.
//   - reqN_ready is combinational. It is high only in IDLE, and only for the granted requester with
//     valid set, so at most one ready is high.
//   - A valid that drops before its ready is simply no transfer.
module piso_tx_sched #(
   parameter int WIDTH = 4,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             res,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_first,
   output logic             ser_last,
   output logic             ser_src,
   output logic             busy,
   output logic [1:0]       dbg_state
);

`ifdef PISO_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             last_grant_q, last_grant_d;
   logic             src_q, src_d;
   logic             grant;
   logic             accept;
   logic             data_bit;
`ifdef PISO_PARITY_EN
   logic             par_q, par_d;
`endif

   // Arbitration: a lone requester wins; when both are valid, the one not granted last time wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
      accept     = (state_q == S_IDLE) && (req0_valid || req1_valid);
      req0_ready = accept && !grant;
      req1_ready = accept && grant;
   end

   // Next-state logic: load on accept, shift during the frame, count off the idle gap.
   always_comb begin
      state_d      = state_q;
      sreg_d       = sreg_q;
      cnt_d        = cnt_q;
      gap_d        = gap_q;
      last_grant_d = last_grant_q;
      src_d        = src_q;
`ifdef PISO_PARITY_EN
      par_d        = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               sreg_d       = grant ? req1_data : req0_data;
               src_d        = grant;
               last_grant_d = grant;
               cnt_d        = '0;
`ifdef PISO_PARITY_EN
               par_d        = grant ? ^req1_data : ^req0_data;
`endif
               state_d      = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               gap_d   = '0;
               state_d = (GAP > 0) ? S_GAP : S_IDLE;
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers. Reset aborts any frame in flight, and req0 wins the first contest.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q      <= S_IDLE;
         sreg_q       <= '0;
         cnt_q        <= '0;
         gap_q        <= '0;
         last_grant_q <= 1'b1;
         src_q        <= 1'b0;
`ifdef PISO_PARITY_EN
         par_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sreg_q       <= sreg_d;
         cnt_q        <= cnt_d;
         gap_q        <= gap_d;
         last_grant_q <= last_grant_d;
         src_q        <= src_d;
`ifdef PISO_PARITY_EN
         par_q        <= par_d;
`endif
      end
   end

   // Serial outputs: everything is quiet outside SHIFT; framing comes from the bit counter.
   always_comb begin
`ifdef PISO_PARITY_EN
      data_bit = (cnt_q == CNT_W'(WIDTH)) ? par_q : sreg_q[WIDTH-1];
`else
      data_bit = sreg_q[WIDTH-1];
`endif
      ser_valid = (state_q == S_SHIFT);
      ser_out   = ser_valid && data_bit;
      ser_first = ser_valid && (cnt_q == '0);
      ser_last  = ser_valid && (cnt_q == LAST_CNT);
      ser_src   = src_q;
      busy      = (state_q != S_IDLE);
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_piso_tx_sched.sv
// tb_piso_tx_sched: directed and random stimulus for piso_tx_sched (WIDTH=4, GAP=1).
// The reference model keeps an expected queue of per-cycle output vectors. Whenever the queue is empty,
// the scheduler is free, so a grant is decided from the arbitration rules. Each grant appends a whole
// frame, followed by the idle gap.
module tb_piso_tx_sched;
   localparam int WIDTH = 4;
   localparam int GAP   = 1;
`ifdef PISO_PARITY_EN
   localparam int FL = WIDTH + 1;
`else
   localparam int FL = WIDTH;
`endif

   logic clk = 1'b0;
   logic res = 1'b0;
   logic req0_valid = 1'b0, req1_valid = 1'b0;
   logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
   logic req0_ready, req1_ready;
   logic ser_out, ser_valid, ser_first, ser_last, ser_src, busy;
   logic [1:0] dbg_state;

   piso_tx_sched #(.WIDTH(WIDTH), .GAP(GAP)) dut (
      .clk(clk), .res(res),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .ser_out(ser_out), .ser_valid(ser_valid), .ser_first(ser_first),
      .ser_last(ser_last), .ser_src(ser_src), .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Scoreboard entry: {busy, valid, out, first, last, src}.
   logic [5:0] exp_q[$];
   logic       last_g = 1'b1;

   // Producer state: each valid is held until the model grants that requester.
   logic             p0_v = 1'b0, p1_v = 1'b0;
   logic [WIDTH-1:0] p0_d = '0, p1_d = '0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic push_frame(input logic src, input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] sh;
      logic             b;
      sh = d;
      for (int i = 0; i < FL; i++) begin
         if (i < WIDTH) begin
            b  = sh[WIDTH-1];
            sh = sh << 1;
         end else begin
            b = ^d;
         end
         exp_q.push_back({1'b1, 1'b1, b, (i == 0), (i == FL - 1), src});
      end
      for (int i = 0; i < GAP; i++) exp_q.push_back(6'b100000);
   endtask

   // One clock cycle. Entered at a falling edge: drive inputs, predict, check, then advance.
   task automatic step();
      logic [5:0] cur;
      logic       idle, g, granted, e_r0, e_r1;
      req0_valid = p0_v; req0_data = p0_d;
      req1_valid = p1_v; req1_data = p1_d;
      #1;
      if (exp_q.size() > 0) begin
         cur  = exp_q.pop_front();
         idle = 1'b0;
      end else begin
         cur  = 6'b0;
         idle = 1'b1;
      end
      granted = 1'b0; g = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
      if (idle && (p0_v || p1_v)) begin
         g       = (p0_v && p1_v) ? ~last_g : p1_v;
         granted = 1'b1;
         last_g  = g;
         e_r0    = !g;
         e_r1    = g;
         push_frame(g, g ? p1_d : p0_d);
      end
      chk("req0_ready", {7'b0, req0_ready}, {7'b0, e_r0});
      chk("req1_ready", {7'b0, req1_ready}, {7'b0, e_r1});
      chk("busy_valid_out_first_last",
          {3'b0, busy, ser_valid, ser_out, ser_first, ser_last}, {3'b0, cur[5:1]});
      chk("first_last_excl", {7'b0, ser_first && ser_last}, 8'h00);
      if (cur[4]) chk("ser_src", {7'b0, ser_src}, {7'b0, cur[0]});
      @(posedge clk);
      @(negedge clk);
      if (granted) begin
         if (g) p1_v = 1'b0;
         else   p0_v = 1'b0;
      end
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_outs"}, {2'b0, ser_out, ser_valid, ser_first, ser_last, ser_src, busy}, 8'h00);
      chk({tag, "_ready"}, {6'b0, req0_ready, req1_ready}, 8'h00);
      chk({tag, "_state"}, {6'b0, dbg_state}, 8'h00);
   endtask

   // Asynchronous reset in the middle of a cycle. Outputs must drop at once.
   task automatic async_reset();
      #2;
      res  = 1'b0;
      p0_v = 1'b0; p1_v = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      check_quiet("async_rst");
      exp_q.delete();
      last_g = 1'b1;
      @(negedge clk);
      @(negedge clk);
      res = 1'b1;
   endtask

   initial begin
      // Power-up reset.
      repeat (2) @(negedge clk);
      check_quiet("por");
      res = 1'b1;

      // Single word from req0: 1001.
      p0_v = 1'b1; p0_d = 4'b1001;
      repeat (8) step();

      // Both held after a fresh reset: req0 first, then req1; then reassert both.
      async_reset();
      p0_v = 1'b1; p0_d = 4'b1010;
      p1_v = 1'b1; p1_d = 4'b0110;
      repeat (14) step();
      p0_v = 1'b1; p0_d = 4'b0011;
      p1_v = 1'b1; p1_d = 4'b1100;
      repeat (14) step();

      // req1 valid continuously with new data per accept.
      for (int i = 0; i < 24; i++) begin
         if (!p1_v) begin
            p1_v = 1'b1;
            p1_d = WIDTH'($urandom_range(0, 15));
         end
         step();
      end
      p1_v = 1'b0;
      repeat (3) step();

      // Reset after two bits of 1001, then both valid: req0 must win.
      p0_v = 1'b1; p0_d = 4'b1001;
      repeat (3) step();
      async_reset();
      p0_v = 1'b1; p0_d = 4'b0101;
      p1_v = 1'b1; p1_d = 4'b1110;
      repeat (14) step();

      // One-cycle req0 pulse while busy: no ready, no extra frame.
      p0_v = 1'b1; p0_d = 4'b1111;
      repeat (2) step();
      p0_v = 1'b1; p0_d = 4'b0001;
      step();
      p0_v = 1'b0;
      repeat (8) step();

      // Random traffic, with occasional withdrawal of a waiting request while busy.
      for (int i = 0; i < 400; i++) begin
         if (!p0_v && $urandom_range(0, 2) == 0) begin
            p0_v = 1'b1; p0_d = WIDTH'($urandom_range(0, 15));
         end else if (p0_v && exp_q.size() > 1 && $urandom_range(0, 9) == 0) begin
            p0_v = 1'b0;
         end
         if (!p1_v && $urandom_range(0, 2) == 0) begin
            p1_v = 1'b1; p1_d = WIDTH'($urandom_range(0, 15));
         end else if (p1_v && exp_q.size() > 1 && $urandom_range(0, 9) == 0) begin
            p1_v = 1'b0;
         end
         step();
      end
      p0_v = 1'b0; p1_v = 1'b0;
      repeat (FL + GAP + 2) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
